// File: rtl/pdm_mic_capture.sv
`default_nettype none
// ============================================================================
// Module   : pdm_mic_capture
// Purpose  : PDM microphone capture. Generates the mic clock, synchronizes
//            the 1-bit PDM stream, decimates by counting ones over DECIM bits
//            and queues PCM samples in a FIFO with a valid/ready interface.
// Options  : `define PDM_SIGNED_OUT_EN -> samples are 2*ones-DECIM (signed)
// Revision : 1.0 - initial release
// ============================================================================
module pdm_mic_capture #(
    parameter int CLK_DIV    = 20,
    parameter int DECIM      = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mic_Enable,
    input  logic        Mic_Data,
    output logic        Mic_Clk,
    output logic        Mic_LRSel,
    output logic [15:0] Sample_Data,
    output logic        Sample_Valid,
    input  logic        Sample_Ready,
    output logic [6:0]  Fifo_Count,
    output logic        Overflow,
    input  logic        Overflow_Clr
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(DECIM);
    localparam int ACC_W = $clog2(DECIM) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DECIM - 1);
    localparam logic [6:0]       FULL_CNT = 7'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               cnt_en;
    logic               clear;

    logic               data_meta;
    logic               data_sync;
    logic [DIV_W-1:0]   div_cnt;
    logic               mic_clk_q;
    logic               div_tc;
    logic               strobe;
    logic [CNT_W-1:0]   bit_cnt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   window_sum;
    logic               window_end;
    logic [15:0]        window_value;
    logic               push_pending;
    logic [15:0]        push_data;

    logic [15:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_next;
    logic [6:0]         count;
    logic [6:0]         count_next;
    logic               full;
    logic               do_pop;
    logic               do_push;
    logic               drop;
    logic [15:0]        head_next;

    assign Mic_LRSel    = 1'b0;
    assign Mic_Clk      = mic_clk_q;
    assign Fifo_Count   = count;

    // Window state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state: capture runs while enabled; leaving RUN clears the window
    always_comb begin
        state_next = state;
        cnt_en     = 1'b0;
        clear      = 1'b0;
        case (state)
            ST_IDLE: begin
                clear = 1'b1;
                if (Mic_Enable) begin
                    state_next = ST_RUN;
                    cnt_en     = 1'b1;
                    clear      = 1'b0;
                end
            end
            ST_RUN: begin
                if (Mic_Enable) begin
                    cnt_en = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                    clear      = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Two-flop synchronizer for the asynchronous PDM data
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            data_meta <= 1'b0;
            data_sync <= 1'b0;
        end else begin
            data_meta <= Mic_Data;
            data_sync <= data_meta;
        end
    end

    assign div_tc = (div_cnt == DIV_LAST);
    // Sample on the cycle the mic clock is about to fall
    assign strobe = cnt_en && div_tc && mic_clk_q;

    // Mic clock divider; forced low whenever capture is stopped
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_cnt   <= '0;
            mic_clk_q <= 1'b0;
        end else if (clear) begin
            div_cnt   <= '0;
            mic_clk_q <= 1'b0;
        end else if (cnt_en) begin
            if (div_tc) begin
                div_cnt   <= '0;
                mic_clk_q <= ~mic_clk_q;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    assign window_sum = acc + ACC_W'(data_sync);
    assign window_end = strobe && (bit_cnt == BIT_LAST);

`ifdef PDM_SIGNED_OUT_EN
    // Centre the ones count around zero: range -DECIM..+DECIM
    assign window_value = 16'({window_sum, 1'b0}) - 16'(DECIM);
`else
    assign window_value = 16'(window_sum);
`endif

    // Ones accumulator; the last strobe of a window hands the total to the FIFO
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc          <= '0;
            bit_cnt      <= '0;
            push_pending <= 1'b0;
            push_data    <= '0;
        end else begin
            push_pending <= window_end;
            if (window_end) push_data <= window_value;
            if (clear) begin
                acc     <= '0;
                bit_cnt <= '0;
            end else if (strobe) begin
                if (window_end) begin
                    acc     <= '0;
                    bit_cnt <= '0;
                end else begin
                    acc     <= window_sum;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign full       = (count == FULL_CNT);
    assign do_pop     = Sample_Valid && Sample_Ready;
    assign do_push    = push_pending && (!full || do_pop);
    assign drop       = push_pending && full && !do_pop;
    assign count_next = count + 7'(do_push) - 7'(do_pop);
    assign rd_next    = rd_ptr + PTR_W'(do_pop);

    // Next head: bypass the incoming sample when it lands in the head slot
    always_comb begin
        head_next = '0;
        if (count_next != 7'd0) begin
            if (do_push && (rd_next == wr_ptr)) head_next = push_data;
            else                                head_next = mem[rd_next];
        end
    end

    // FIFO storage (no reset needed; occupancy is tracked by count)
    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // FIFO pointers, occupancy, registered head and sticky overflow
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            Sample_Data  <= '0;
            Sample_Valid <= 1'b0;
            Overflow     <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr       <= rd_next;
            count        <= count_next;
            Sample_Data  <= head_next;
            Sample_Valid <= (count_next != 7'd0);
            if (drop)              Overflow <= 1'b1;
            else if (Overflow_Clr) Overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pdm_mic_capture.sv
`default_nettype none
module tb_pdm_mic_capture;

    localparam int CLK_DIV = 20;
    localparam int DECIM   = 64;
    localparam int DEPTH   = 16;
    localparam int PERIOD  = 2 * CLK_DIV;
    localparam int WIN     = PERIOD * DECIM;

`ifdef PDM_SIGNED_OUT_EN
    localparam logic [15:0] EXP_ONES = 16'd64;
    localparam logic [15:0] EXP_ALT  = 16'd0;
    localparam logic [15:0] EXP_ZERO = 16'hFFC0;
`else
    localparam logic [15:0] EXP_ONES = 16'd64;
    localparam logic [15:0] EXP_ALT  = 16'd32;
    localparam logic [15:0] EXP_ZERO = 16'd0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Mic_Enable = 1'b0;
    logic        Mic_Data = 1'b0;
    logic        Sample_Ready = 1'b0;
    logic        Overflow_Clr = 1'b0;
    logic        Mic_Clk;
    logic        Mic_LRSel;
    logic [15:0] Sample_Data;
    logic        Sample_Valid;
    logic [6:0]  Fifo_Count;
    logic        Overflow;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    pdm_mic_capture #(
        .CLK_DIV    (CLK_DIV),
        .DECIM      (DECIM),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Mic_Enable   (Mic_Enable),
        .Mic_Data     (Mic_Data),
        .Mic_Clk      (Mic_Clk),
        .Mic_LRSel    (Mic_LRSel),
        .Sample_Data  (Sample_Data),
        .Sample_Valid (Sample_Valid),
        .Sample_Ready (Sample_Ready),
        .Fifo_Count   (Fifo_Count),
        .Overflow     (Overflow),
        .Overflow_Clr (Overflow_Clr)
    );

    // ---------------- reference model ----------------
    logic [15:0] q[$];
    bit          m_ovf = 1'b0;
    bit          m_mclk = 1'b0;
    int          en_k = 0;
    int          nbits = 0;
    int          ones = 0;
    bit          pend = 1'b0;
    logic [15:0] pend_val = '0;
    bit          h0 = 1'b0;
    bit          h1 = 1'b0;

    function automatic logic [15:0] win_value(input int n);
`ifdef PDM_SIGNED_OUT_EN
        return 16'(2 * n - DECIM);
`else
        return 16'(n);
`endif
    endfunction

    always @(posedge Clk or posedge Reset) begin : model
        bit pop, drop, b;
        if (Reset) begin
            q.delete();
            m_ovf = 0; m_mclk = 0; en_k = 0; nbits = 0; ones = 0;
            pend = 0; h0 = 0; h1 = 0;
        end else begin
            pop  = (q.size() != 0) && Sample_Ready;
            drop = pend && (q.size() == DEPTH) && !pop;
            if (pop) void'(q.pop_front());
            if (pend && !drop) q.push_back(pend_val);
            if (drop) m_ovf = 1;
            else if (Overflow_Clr) m_ovf = 0;
            pend = 0;
            b  = h1;
            h1 = h0;
            h0 = Mic_Data;
            if (Mic_Enable) begin
                en_k++;
                m_mclk = ((en_k / CLK_DIV) % 2) == 1;
                if (en_k % PERIOD == 0) begin
                    ones += int'(b);
                    nbits++;
                    if (nbits == DECIM) begin
                        pend = 1; pend_val = win_value(ones);
                        ones = 0; nbits = 0;
                    end
                end
            end else begin
                en_k = 0; m_mclk = 0; ones = 0; nbits = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge Clk) begin
        check("mic_clk", 32'(Mic_Clk), 32'(m_mclk));
        check("lrsel", 32'(Mic_LRSel), 32'd0);
        check("valid", 32'(Sample_Valid), 32'(q.size() != 0));
        check("count", 32'(Fifo_Count), 32'(q.size()));
        check("overflow", 32'(Overflow), 32'(m_ovf));
        if (q.size() != 0) check("data", 32'(Sample_Data), 32'(q[0]));
    end

    // ---------------- stimulus ----------------
    task automatic run(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    // mode 0: all zeros, 1: all ones, 2: alternate per mic clock period
    task automatic bits(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            Mic_Data = (mode == 2) ? i[0] : mode[0];
            run(PERIOD);
        end
    endtask

    task automatic drain();
        Sample_Ready = 1'b1;
        run(DEPTH + 4);
        Sample_Ready = 1'b0;
        check("drained_count", 32'(Fifo_Count), 32'd0);
    endtask

    initial begin
        int rise_at;
        #1 Reset = 1'b1;
        run(3);
        check("rst_mic_clk", 32'(Mic_Clk), 32'd0);
        check("rst_data", 32'(Sample_Data), 32'd0);
        check("rst_valid", 32'(Sample_Valid), 32'd0);
        check("rst_count", 32'(Fifo_Count), 32'd0);
        check("rst_ovf", 32'(Overflow), 32'd0);
        Reset = 1'b0;

        // idle: nothing moves
        run(200);
        check("idle_mic_clk", 32'(Mic_Clk), 32'd0);
        check("idle_valid", 32'(Sample_Valid), 32'd0);
        check("idle_count", 32'(Fifo_Count), 32'd0);

        // all ones, first mic clock rise
        Mic_Enable = 1'b1; Mic_Data = 1'b1;
        rise_at = -1;
        for (int i = 1; i <= 100; i++) begin
            run(1);
            if (Mic_Clk === 1'b1) begin
                rise_at = i;
                break;
            end
        end
        check("first_rise", 32'(rise_at), 32'(CLK_DIV));
        bits(2 * DECIM, 1);
        check("ones_count", 32'(Fifo_Count), 32'd2);
        check("ones_data", 32'(Sample_Data), 32'(EXP_ONES));
        drain();
        Mic_Enable = 1'b0; run(5);

        // alternating stream
        Mic_Enable = 1'b1;
        bits(2 * DECIM, 2);
        run(5);
        check("alt_count", 32'(Fifo_Count), 32'd2);
        check("alt_data", 32'(Sample_Data), 32'(EXP_ALT));
        drain();
        Mic_Enable = 1'b0; run(5);

        // all zeros with no consumer: fill then overflow
        Mic_Data = 1'b0; Mic_Enable = 1'b1;
        run(DEPTH * WIN + 3);
        check("full_count", 32'(Fifo_Count), 32'(DEPTH));
        check("full_no_ovf", 32'(Overflow), 32'd0);
        check("zero_data", 32'(Sample_Data), 32'(EXP_ZERO));
        run(WIN);
        check("ovf_set", 32'(Overflow), 32'd1);
        check("ovf_count", 32'(Fifo_Count), 32'(DEPTH));
        Mic_Enable = 1'b0; Overflow_Clr = 1'b1;
        run(1);
        Overflow_Clr = 1'b0;
        check("ovf_clr", 32'(Overflow), 32'd0);
        run(3);

        // full FIFO, pop on the exact push cycle
        Mic_Data = 1'b1; Mic_Enable = 1'b1;
        run(WIN);
        Sample_Ready = 1'b1;
        run(1);
        Sample_Ready = 1'b0;
        check("pp_count", 32'(Fifo_Count), 32'(DEPTH));
        check("pp_ovf", 32'(Overflow), 32'd0);
        Mic_Enable = 1'b0; run(2);
        drain();

        // disable mid-window at bit 30, then a fresh window
        Mic_Enable = 1'b1;
        run(30 * PERIOD);
        Mic_Enable = 1'b0;
        run(10);
        check("partial_dropped", 32'(Fifo_Count), 32'd0);
        Mic_Enable = 1'b1;
        run(WIN + 3);
        check("fresh_count", 32'(Fifo_Count), 32'd1);
        check("fresh_data", 32'(Sample_Data), 32'(EXP_ONES));

        // reset mid-capture
        run(1000);
        Reset = 1'b1;
        run(2);
        check("mid_rst_count", 32'(Fifo_Count), 32'd0);
        check("mid_rst_valid", 32'(Sample_Valid), 32'd0);
        check("mid_rst_clk", 32'(Mic_Clk), 32'd0);
        Reset = 1'b0;
        run(WIN + 3);
        check("post_rst_count", 32'(Fifo_Count), 32'd1);
        check("post_rst_data", 32'(Sample_Data), 32'(EXP_ONES));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
